// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the SRAM/CRC job sequencer.
package crc_pkg;

    localparam logic [3:0]  CRC_TYPE_32 = 4'hF;
    localparam logic [3:0]  CRC_TYPE_16 = 4'h0;
    localparam logic [31:0] CRC16_MASK  = 32'h0000FFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } crc_seq_state_t;

endpackage

// File: rtl/crc_seq_ctrl.sv
// Walks a descriptor's SRAM words through the CRC engine, chaining each result
// into the next word's init, and returns the final CRC on a valid/ready port.
//
// state | meaning
// IDLE  | ready for a descriptor; validates and latches it on handshake
// ISSUE | engine pins held for ENG_LAT cycles per word, result chained into acc
// RESP  | rsp_valid high, result held until rsp_ready
module crc_seq_ctrl
    import crc_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 11,
    parameter int ADDR_STRIDE = 4,
    parameter int LEN_WIDTH   = 10,
    parameter int ENG_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [LEN_WIDTH-1:0]  req_len,
    input  logic [3:0]            req_type,
    input  logic [DATA_WIDTH-1:0] req_init,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_crc,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  eng_write_en,
    output logic [ADDR_WIDTH-1:0] eng_address,
    output logic [3:0]            eng_crc_type,
    output logic [DATA_WIDTH-1:0] eng_init,
    input  logic [DATA_WIDTH-1:0] eng_crc_out
);

    localparam int EXT_W = ADDR_WIDTH + LEN_WIDTH + 1;
    localparam int LAT_W = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;

    crc_seq_state_t        state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [DATA_WIDTH-1:0] acc;
    logic [3:0]            type_q;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [LAT_W-1:0]      lat_cnt;
    logic [DATA_WIDTH-1:0] rsp_crc_q;
    logic                  rsp_err_q;

    logic [EXT_W-1:0]      end_addr;
    logic                  req_bad;
    logic [DATA_WIDTH-1:0] crc_masked;
    logic                  lat_done;

    function automatic logic [DATA_WIDTH-1:0] type_mask(input logic [3:0] t);
        return (t == CRC_TYPE_16) ? DATA_WIDTH'(CRC16_MASK) : '1;
    endfunction

    // Last-word address is formed wide enough that it can never wrap.
    always_comb begin
        end_addr = EXT_W'(req_addr)
                 + EXT_W'(req_len - LEN_WIDTH'(1)) * EXT_W'(ADDR_STRIDE);
        req_bad  = (req_len == '0)
                 || ((req_type != CRC_TYPE_32) && (req_type != CRC_TYPE_16))
                 || ((req_addr % ADDR_WIDTH'(ADDR_STRIDE)) != '0)
                 || (end_addr > EXT_W'({ADDR_WIDTH{1'b1}}));
    end

    assign crc_masked = eng_crc_out & type_mask(type_q);
    assign lat_done   = (lat_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cur_addr  <= '0;
            acc       <= '0;
            type_q    <= '0;
            remaining <= '0;
            lat_cnt   <= '0;
            rsp_crc_q <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_bad) begin
                            // Engine pins are left untouched on a reject.
                            rsp_crc_q <= req_init & type_mask(req_type);
                            rsp_err_q <= 1'b1;
                            state     <= RESP;
                        end else begin
                            cur_addr  <= req_addr;
                            acc       <= req_init;
                            type_q    <= req_type;
                            remaining <= req_len;
                            lat_cnt   <= LAT_W'(ENG_LAT - 1);
                            state     <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (lat_done) begin
                        acc       <= crc_masked;
                        remaining <= remaining - LEN_WIDTH'(1);
                        cur_addr  <= cur_addr + ADDR_WIDTH'(ADDR_STRIDE);
                        lat_cnt   <= LAT_W'(ENG_LAT - 1);
                        if (remaining == LEN_WIDTH'(1)) begin
                            rsp_crc_q <= crc_masked;
                            rsp_err_q <= 1'b0;
                            state     <= RESP;
                        end
                    end else begin
                        lat_cnt <= lat_cnt - LAT_W'(1);
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign rsp_valid    = (state == RESP);
    assign rsp_crc      = rsp_crc_q;
    assign rsp_err      = rsp_err_q;
    assign eng_write_en = 1'b1;
    assign eng_address  = cur_addr;
    assign eng_init     = acc;
    assign eng_crc_type = type_q;

endmodule

// File: tb/tb_crc_seq_ctrl.sv
// Self-checking bench for crc_seq_ctrl with a behavioural SRAM+CRC engine stand-in.
module tb_crc_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_addr;
    logic [9:0]  req_len;
    logic [3:0]  req_type;
    logic [31:0] req_init;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_crc;
    logic        rsp_err;
    logic        busy;
    logic        eng_write_en;
    logic [10:0] eng_address;
    logic [3:0]  eng_crc_type;
    logic [31:0] eng_init;
    logic [31:0] eng_crc_out;

    int checks   = 0;
    int failures = 0;

    logic [31:0] sram [0:511];
    logic [31:0] m_exp_crc;
    logic        m_exp_err;
    logic [31:0] last_crc;
    logic        last_err;

    crc_seq_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .req_len      (req_len),
        .req_type     (req_type),
        .req_init     (req_init),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_crc      (rsp_crc),
        .rsp_err      (rsp_err),
        .busy         (busy),
        .eng_write_en (eng_write_en),
        .eng_address  (eng_address),
        .eng_crc_type (eng_crc_type),
        .eng_init     (eng_init),
        .eng_crc_out  (eng_crc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Engine stand-in: the characterised vectors are returned verbatim, anything
    // else goes through a cheap mixing function. CRC-16 results carry junk in
    // the upper half so the sequencer's clearing of those bits is visible.
    function automatic logic [31:0] eng_f(input logic [31:0] w, input logic [31:0] init,
                                          input logic [3:0] t);
        if (w == 32'hbabecafe && init == 32'hffffffff && t == 4'hF) return 32'ha5769b57;
        if (w == 32'hbabecafe && init == 32'h00000000 && t == 4'h0) return 32'h5a5abe08;
        if (t == 4'hF) return {init[30:0], init[31]} ^ w ^ 32'h04c11db7;
        return {16'ha5a5, ({init[14:0], init[15]} ^ w[15:0] ^ w[31:16] ^ 16'h1021)};
    endfunction

    assign eng_crc_out = eng_f(sram[eng_address[10:2]], eng_init, eng_crc_type);

    // Whole-job expectation: {err, crc}.
    function automatic logic [32:0] model_job(input int addr, input int len,
                                              input logic [3:0] t, input logic [31:0] init);
        logic [31:0] acc;
        logic        bad;
        bad = (len == 0) || !(t == 4'h0 || t == 4'hF) || ((addr % 4) != 0)
              || ((addr + (len - 1) * 4) > 2047);
        if (bad) return {1'b1, (t == 4'h0) ? (init & 32'h0000ffff) : init};
        acc = init;
        for (int k = 0; k < len; k++) begin
            acc = eng_f(sram[(addr + 4 * k) / 4], acc, t);
            if (t == 4'h0) acc = acc & 32'h0000ffff;
        end
        return {1'b0, acc};
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            check("eng_write_en", 32'(eng_write_en), 32'd1);
            check("ready_vs_busy", 32'(req_ready), 32'(!busy));
            if (rsp_valid) begin
                check("rsp_crc_model", rsp_crc, m_exp_crc);
                check("rsp_err_model", 32'(rsp_err), 32'(m_exp_err));
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_rsp_crc"}, rsp_crc, 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_eng_address"}, 32'(eng_address), 32'd0);
        check({tag, "_eng_init"}, eng_init, 32'd0);
        check({tag, "_eng_crc_type"}, 32'(eng_crc_type), 32'd0);
        check({tag, "_eng_write_en"}, 32'(eng_write_en), 32'd1);
    endtask

    // Called at a negedge; returns at the negedge right after the accept edge.
    task automatic issue_req(input int addr, input int len, input logic [3:0] t,
                             input logic [31:0] init);
        req_addr  = 11'(addr);
        req_len   = 10'(len);
        req_type  = t;
        req_init  = init;
        req_valid = 1'b1;
        {m_exp_err, m_exp_crc} = model_job(addr, len, t, init);
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic walk(input int addr, input int len, input logic [3:0] t,
                        input logic [31:0] init);
        logic [31:0] acc;
        acc = init;
        for (int k = 0; k < len; k++) begin
            check("eng_address_seq", 32'(eng_address), 32'(addr + 4 * k));
            check("eng_init_chain", eng_init, acc);
            check("eng_crc_type", 32'(eng_crc_type), 32'(t));
            check("busy_issue", 32'(busy), 32'd1);
            check("rsp_valid_early", 32'(rsp_valid), 32'd0);
            acc = eng_f(sram[(addr + 4 * k) / 4], acc, t);
            if (t == 4'h0) acc = acc & 32'h0000ffff;
            @(negedge clk);
        end
        check("rsp_valid_timing", 32'(rsp_valid), 32'd1);
        last_crc = rsp_crc;
        last_err = rsp_err;
    endtask

    task automatic finish_rsp(input int hold);
        for (int h = 0; h < hold; h++) begin
            check("rsp_valid_hold", 32'(rsp_valid), 32'd1);
            check("rsp_crc_stable", rsp_crc, last_crc);
            check("req_ready_resp", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("rsp_valid_drop", 32'(rsp_valid), 32'd0);
        check("idle_after_rsp", 32'(busy), 32'd0);
    endtask

    task automatic run_job(input int addr, input int len, input logic [3:0] t,
                           input logic [31:0] init, input int hold);
        logic [10:0] prev_addr;
        logic [31:0] prev_init;
        logic [3:0]  prev_type;
        prev_addr = eng_address;
        prev_init = eng_init;
        prev_type = eng_crc_type;
        issue_req(addr, len, t, init);
        if (m_exp_err) begin
            check("rej_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rej_eng_address", 32'(eng_address), 32'(prev_addr));
            check("rej_eng_init", eng_init, prev_init);
            check("rej_eng_type", 32'(eng_crc_type), 32'(prev_type));
            last_crc = rsp_crc;
            last_err = rsp_err;
        end else begin
            walk(addr, len, t, init);
        end
        finish_rsp(hold);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        req_type  = '0;
        req_init  = '0;
        m_exp_crc = '0;
        m_exp_err = 1'b0;
        last_crc  = '0;
        last_err  = 1'b0;
        for (int i = 0; i < 512; i++) sram[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0103;
        sram[0]   = 32'hbabecafe;
        sram[1]   = 32'h01234567;
        sram[2]   = 32'h89abcdef;
        sram[3]   = 32'hdeadbeef;
        sram[511] = 32'hbabecafe;

        repeat (3) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_job(0, 1, 4'hF, 32'hffffffff, 0);
        check("single32_literal", last_crc, 32'ha5769b57);
        check("single32_err", 32'(last_err), 32'd0);

        run_job(0, 1, 4'h0, 32'h00000000, 2);
        check("single16_literal", last_crc, 32'h0000be08);

        run_job(0, 4, 4'hF, 32'hffffffff, 1);
        run_job(12'h7fc, 1, 4'hF, 32'hffffffff, 0);
        check("top_word_literal", last_crc, 32'ha5769b57);

        run_job(0, 0, 4'hF, 32'h12345678, 0);
        check("rej_len0_literal", last_crc, 32'h12345678);
        check("rej_len0_err", 32'(last_err), 32'd1);
        run_job(0, 1, 4'h3, 32'hcafef00d, 0);
        check("rej_type_literal", last_crc, 32'hcafef00d);
        run_job(12'h7fc, 2, 4'hF, 32'h0badf00d, 0);
        check("rej_ovf_literal", last_crc, 32'h0badf00d);
        run_job(2, 1, 4'hF, 32'h55aa55aa, 0);
        check("rej_align_literal", last_crc, 32'h55aa55aa);
        run_job(0, 0, 4'h0, 32'hdeadbeef, 0);
        check("rej_len0_16_literal", last_crc, 32'h0000beef);

        // Backpressure with a second descriptor waiting.
        issue_req(8, 2, 4'hF, 32'h13579bdf);
        walk(8, 2, 4'hF, 32'h13579bdf);
        req_addr  = 11'd0;
        req_len   = 10'd1;
        req_type  = 4'hF;
        req_init  = 32'hffffffff;
        req_valid = 1'b1;
        for (int h = 0; h < 5; h++) begin
            check("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp_rsp_crc", rsp_crc, last_crc);
            check("bp_req_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_not_taken_at_e1", 32'(busy), 32'd0);
        check("bp_ready_after_e1", 32'(req_ready), 32'd1);
        {m_exp_err, m_exp_crc} = model_job(0, 1, 4'hF, 32'hffffffff);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_taken_next", 32'(busy), 32'd1);
        walk(0, 1, 4'hF, 32'hffffffff);
        finish_rsp(0);
        check("bp_second_literal", last_crc, 32'ha5769b57);

        // Reset while word 2 of an 8-word job is on the engine pins.
        issue_req(0, 8, 4'hF, 32'hffffffff);
        @(negedge clk);
        @(negedge clk);
        check("mid_job_addr", 32'(eng_address), 32'd8);
        #2 rst_n = 1'b0;
        #1 check_reset_values("async_reset");
        @(negedge clk);
        check("reset_no_rsp", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_no_rsp", 32'(rsp_valid), 32'd0);
        run_job(0, 1, 4'hF, 32'hffffffff, 0);
        check("post_reset_literal", last_crc, 32'ha5769b57);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
